// File: rtl/pll_reconfig_sequencer.sv
// pll_reconfig_sequencer
//   Programs a PLL reconfiguration block over an Avalon-MM master port.
//   A start pulse in IDLE latches the M, N and per-channel C counter words,
//   then the sequencer writes mode, N, M, every enabled C counter and the
//   start register, and finally polls the status register until the
//   reconfiguration reports completion or the poll budget runs out.
//
// Ports
//   clk_clk, reset_reset         clock, synchronous active-high reset
//   start                        single-cycle request pulse (ignored while busy)
//   m_val, n_val                 18-bit M and N counter words
//   c_val, c_en                  NUM_CH 18-bit C counter words and their write enables
//   mgmt_*                       Avalon-MM master (address, read, write, writedata,
//                                readdata, waitrequest)
//   busy                         sequence in progress
//   done, err                    one-cycle success / poll-timeout pulses
module pll_reconfig_sequencer #(
    parameter int NUM_CH  = 5,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic                   start,
    input  logic [17:0]            m_val,
    input  logic [17:0]            n_val,
    input  logic [NUM_CH*18-1:0]   c_val,
    input  logic [NUM_CH-1:0]      c_en,
    output logic [5:0]             mgmt_address,
    output logic                   mgmt_read,
    output logic                   mgmt_write,
    output logic [31:0]            mgmt_writedata,
    input  logic [31:0]            mgmt_readdata,
    input  logic                   mgmt_waitrequest,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_MODE,
        ST_WR_N,
        ST_WR_M,
        ST_WR_C,
        ST_WR_START,
        ST_POLL
    } state_e;

    state_e                 state_q;
    logic [17:0]            m_q;
    logic [17:0]            n_q;
    logic [NUM_CH*18-1:0]   c_val_q;
    logic [NUM_CH-1:0]      c_en_q;
    logic [4:0]             ch_idx_q;
    logic [15:0]            poll_cnt_q;
    logic [15:0]            poll_cnt_d;
    logic [5:0]             addr_q;
    logic [31:0]            wdata_q;
    logic                   read_q;
    logic                   write_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;

    logic                   accept;
    logic                   xfer_done;
    logic                   first_found;
    logic [4:0]             first_idx;
    logic [31:0]            first_word;
    logic                   next_found;
    logic [4:0]             next_idx;
    logic [31:0]            next_word;
    logic                   unused_readdata;

    assign accept     = (state_q == ST_IDLE) && start && !reset_reset;
    // A transfer completes only in a cycle where the slave is not stalling us.
    assign xfer_done  = (read_q || write_q) && !mgmt_waitrequest;
    assign poll_cnt_d = poll_cnt_q + 16'd1;
    assign unused_readdata = ^mgmt_readdata[31:1];

    // Channel search: lowest enabled channel overall, and lowest enabled
    // channel above the one currently on the bus. Scanning downward lets the
    // last hit (the lowest index) win, so disabled channels cost no cycles.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (c_en_q[k]) begin
                first_found = 1'b1;
                first_idx   = 5'(k);
            end
            if (c_en_q[k] && (k > int'(ch_idx_q))) begin
                next_found = 1'b1;
                next_idx   = 5'(k);
            end
        end
        first_word = {9'b0, first_idx, c_val_q[18*int'(first_idx) +: 18]};
        next_word  = {9'b0, next_idx,  c_val_q[18*int'(next_idx)  +: 18]};
    end

    // Operand snapshot taken at the accepting edge; later input changes are
    // invisible to the running sequence.
    // NOTE: pure data registers are qualified by the accept strobe and need no reset.
    always_ff @(posedge clk_clk) begin
        if (accept) begin
            m_q     <= m_val;
            n_q     <= n_val;
            c_val_q <= c_val;
            c_en_q  <= c_en;
        end
    end

    // Sequencer. The state names the transfer currently presented on the bus;
    // bus outputs only change on completion, so they hold through waitrequest.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q    <= ST_IDLE;
            ch_idx_q   <= '0;
            poll_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_WR_MODE;
                        busy_q     <= 1'b1;
                        write_q    <= 1'b1;
                        addr_q     <= 6'd0;
                        wdata_q    <= 32'h1;
                        ch_idx_q   <= '0;
                        poll_cnt_q <= '0;
                    end
                end
                ST_WR_MODE: begin
                    if (xfer_done) begin
                        state_q <= ST_WR_N;
                        addr_q  <= 6'd3;
                        wdata_q <= {14'b0, n_q};
                    end
                end
                ST_WR_N: begin
                    if (xfer_done) begin
                        state_q <= ST_WR_M;
                        addr_q  <= 6'd4;
                        wdata_q <= {14'b0, m_q};
                    end
                end
                ST_WR_M: begin
                    if (xfer_done) begin
                        if (first_found) begin
                            state_q  <= ST_WR_C;
                            ch_idx_q <= first_idx;
                            addr_q   <= 6'd5;
                            wdata_q  <= first_word;
                        end else begin
                            state_q <= ST_WR_START;
                            addr_q  <= 6'd2;
                            wdata_q <= 32'h1;
                        end
                    end
                end
                ST_WR_C: begin
                    if (xfer_done) begin
                        if (next_found) begin
                            ch_idx_q <= next_idx;
                            wdata_q  <= next_word;
                        end else begin
                            state_q <= ST_WR_START;
                            addr_q  <= 6'd2;
                            wdata_q <= 32'h1;
                        end
                    end
                end
                ST_WR_START: begin
                    if (xfer_done) begin
                        state_q <= ST_POLL;
                        write_q <= 1'b0;
                        read_q  <= 1'b1;
                        addr_q  <= 6'd1;
                        wdata_q <= '0;
                    end
                end
                ST_POLL: begin
                    if (xfer_done) begin
                        if (mgmt_readdata[0]) begin
                            state_q <= ST_IDLE;
                            read_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            addr_q  <= '0;
                        end else begin
                            poll_cnt_q <= poll_cnt_d;
                            if (poll_cnt_d == 16'(TIMEOUT)) begin
                                state_q <= ST_IDLE;
                                read_q  <= 1'b0;
                                busy_q  <= 1'b0;
                                err_q   <= 1'b1;
                                addr_q  <= '0;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mgmt_address   = addr_q;
    assign mgmt_read      = read_q;
    assign mgmt_write     = write_q;
    assign mgmt_writedata = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule
